// File: rtl/moc_bank_arbiter.sv
// moc_bank_arbiter: shares one single-port RAM macro between NUM_REQ requesters.
// Port 0 (AHB side) has fixed priority over the native ports 1..NUM_REQ-1, which
// are served round-robin. A per-port wait counter forces a grant to any native
// port that has been denied MAX_WAIT cycles in a row. Read data comes back
// RD_LAT cycles after the grant, tagged with the requester index.
module moc_bank_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RAM_ADDR_W = 10,
    parameter int RAM_DATA_W = 32,
    parameter int BYTE_W     = RAM_DATA_W / 8,
    parameter int RD_LAT     = 1,
    parameter int MAX_WAIT   = 7
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*RAM_ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*RAM_DATA_W-1:0]    req_wdata,
    input  logic [NUM_REQ*BYTE_W-1:0]        req_wmask,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [RAM_DATA_W-1:0]            rsp_rdata,
    output logic                             ram_cen,
    output logic                             ram_wen,
    output logic [RAM_ADDR_W-1:0]            ram_addr,
    output logic [RAM_DATA_W-1:0]            ram_wdata,
    output logic [BYTE_W-1:0]                ram_wmask,
    input  logic [RAM_DATA_W-1:0]            ram_rdata,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             starve_ovr
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] wait_cnt [1:NUM_REQ-1];

    logic             gnt_any;
    logic             gnt_ovr;
    logic             gnt_rd;
    logic [ID_W-1:0]  gnt_idx;
    int               rr_cand;

    logic             pipe_vld [RD_LAT];
    logic [ID_W-1:0]  pipe_id  [RD_LAT];

    // Grant selection: starvation override, then port 0, then round-robin from rr_ptr.
    // No grants are issued while reset is asserted so the RAM stays quiet.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ovr = 1'b0;
        gnt_idx = '0;
        rr_cand = 0;
        if (!HRESET) begin
            // Descending scan so the lowest starving index wins.
            for (int i = NUM_REQ - 1; i >= 1; i--) begin
                if (req_valid[i] && wait_cnt[i] == MAX_W) begin
                    gnt_any = 1'b1;
                    gnt_ovr = 1'b1;
                    gnt_idx = ID_W'(i);
                end
            end
            if (!gnt_any && req_valid[0]) begin
                gnt_any = 1'b1;
                gnt_idx = '0;
            end
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                rr_cand = int'(rr_ptr) + k;
                if (rr_cand > NUM_REQ - 1) begin
                    rr_cand = rr_cand - (NUM_REQ - 1);
                end
                for (int j = 1; j < NUM_REQ; j++) begin
                    if (!gnt_any && j == rr_cand && req_valid[j]) begin
                        gnt_any = 1'b1;
                        gnt_idx = ID_W'(j);
                    end
                end
            end
        end
    end

    // Route the grantee's payload to the RAM; everything is zero when idle.
    always_comb begin
        req_ready = '0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        gnt_rd    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && gnt_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                ram_wen      = req_wr[i];
                ram_addr     = req_addr[i*RAM_ADDR_W +: RAM_ADDR_W];
                ram_wdata    = req_wdata[i*RAM_DATA_W +: RAM_DATA_W];
                ram_wmask    = req_wr[i] ? req_wmask[i*BYTE_W +: BYTE_W] : '0;
                gnt_rd       = !req_wr[i];
            end
        end
    end

    assign ram_cen    = gnt_any;
    assign grant_id   = gnt_idx;
    assign starve_ovr = gnt_ovr;

    // Round-robin pointer and per-port wait counters.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_ptr <= ID_W'(1);
            for (int i = 1; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (gnt_any && gnt_idx != '0) begin
                rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : gnt_idx + ID_W'(1);
            end
            for (int i = 1; i < NUM_REQ; i++) begin
                if (!req_valid[i] || (gnt_any && gnt_idx == ID_W'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != MAX_W) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Response tag pipeline, aligned with the RAM read latency; reset drops in-flight reads.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_id[s]  <= '0;
            end
        end else begin
            pipe_vld[0] <= gnt_rd;
            pipe_id[0]  <= gnt_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    // Present the returning word to its requester; shared data bus is zero otherwise.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pipe_vld[RD_LAT-1]) begin
            rsp_rdata = ram_rdata;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pipe_id[RD_LAT-1] == ID_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_moc_bank_arbiter.sv
// Scoreboard bench for moc_bank_arbiter: a behavioural RAM, a reference
// arbitration model that predicts grants and read data, and a monitor that
// matches returned read responses against the expected-response queue.
module tb_moc_bank_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 7;
    localparam int IDW      = $clog2(NUM_REQ);

    logic HCLK = 1'b0;
    logic HRESET;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_wr, rsp_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ*BW-1:0] req_wmask;
    logic [DW-1:0]         rsp_rdata, ram_wdata, ram_rdata;
    logic                  ram_cen, ram_wen, starve_ovr;
    logic [AW-1:0]         ram_addr;
    logic [BW-1:0]         ram_wmask;
    logic [IDW-1:0]        grant_id;

    // Per-requester stimulus state.
    logic [NUM_REQ-1:0] v, wr;
    logic [AW-1:0]      a [NUM_REQ];
    logic [DW-1:0]      d [NUM_REQ];
    logic [BW-1:0]      m [NUM_REQ];

    // Reference model state.
    typedef struct {
        int          id;
        logic [DW-1:0] data;
        longint      due;
    } rsp_t;
    rsp_t          sbq [$];
    rsp_t          e;
    int            m_rr;
    int            m_wait [NUM_REQ];
    logic [DW-1:0] shadow [0:1023];
    int            last_g;
    logic [NUM_REQ-1:0] last_rdy, last_rspv;
    logic [DW-1:0]      last_rdata;
    logic [AW-1:0]      last_addr;
    logic [IDW-1:0]     last_gid;
    logic               last_ovr, last_cen;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    bit     mon_en = 1'b0;

    always #5 HCLK = ~HCLK;

    moc_bank_arbiter #(
        .NUM_REQ(NUM_REQ), .RAM_ADDR_W(AW), .RAM_DATA_W(DW), .BYTE_W(BW),
        .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
        .grant_id(grant_id), .starve_ovr(starve_ovr)
    );

    always_comb begin
        req_valid = v;
        req_wr    = wr;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
            req_wmask[i*BW +: BW] = m[i];
        end
    end

    function automatic logic [DW-1:0] init_word(int k);
        if (k == 'h010) return 32'hDEAD_BEEF;
        if (k == 'h3FF) return 32'h1111_1111;
        return (32'h9E37_79B9 * k) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port RAM, preloaded on the first clock edge.
    logic [DW-1:0] mem  [0:1023];
    logic [DW-1:0] rd_q [RD_LAT];
    bit            mem_loaded = 1'b0;
    always @(posedge HCLK) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
            mem_loaded <= 1'b1;
        end else if (ram_cen && ram_wen) begin
            for (int b = 0; b < BW; b++)
                if (ram_wmask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end else if (ram_cen) begin
            rd_q[0] <= mem[ram_addr];
        end
        for (int s = 1; s < RD_LAT; s++) rd_q[s] <= rd_q[s-1];
    end
    assign ram_rdata = rd_q[RD_LAT-1];

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected response when its cycle comes, otherwise expects silence.
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                tests++;
                if (e.due != cyc || rsp_valid != (NUM_REQ'(1) << e.id) || rsp_rdata != e.data) begin
                    fails++;
                    $display("FAIL rsp: got valid=%b data=%h expected id=%0d data=%h (cycle %0d)",
                             rsp_valid, rsp_rdata, e.id, e.data, cyc);
                end
            end else begin
                tests++;
                if (rsp_valid != '0 || rsp_rdata != '0) begin
                    fails++;
                    $display("FAIL rsp_idle: got valid=%b data=%h expected 0 (cycle %0d)",
                             rsp_valid, rsp_rdata, cyc);
                end
            end
        end
    end

    // Predict this cycle's grant from the arbitration rules, compare, then advance the model.
    task automatic step_check();
        int g;
        logic ovr;
        logic [NUM_REQ-1:0] exp_rdy;
        g   = -1;
        ovr = 1'b0;
        if (!HRESET) begin
            for (int i = 1; i < NUM_REQ; i++)
                if (g < 0 && v[i] && m_wait[i] >= MAX_WAIT) begin g = i; ovr = 1'b1; end
            if (g < 0 && v[0]) g = 0;
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                int c;
                c = m_rr + k;
                if (c > NUM_REQ - 1) c -= NUM_REQ - 1;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready", req_ready, exp_rdy);
        chk("grant_id", grant_id, (g < 0) ? 0 : g);
        chk("starve_ovr", starve_ovr, ovr);
        chk("ram_cen", ram_cen, g >= 0);
        if (g >= 0) begin
            chk("ram_wen", ram_wen, wr[g]);
            chk("ram_addr", ram_addr, a[g]);
            chk("ram_wdata", ram_wdata, d[g]);
            chk("ram_wmask", ram_wmask, wr[g] ? m[g] : '0);
        end else begin
            chk("idle_bus", {ram_wen, ram_addr, ram_wmask}, 0);
            chk("idle_wdata", ram_wdata, 0);
        end

        last_rdy = req_ready; last_gid = grant_id; last_ovr = starve_ovr;
        last_cen = ram_cen;   last_addr = ram_addr;
        last_rspv = rsp_valid; last_rdata = rsp_rdata;
        last_g = g;

        if (HRESET) begin
            m_rr = 1;
            for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
            sbq.delete();
        end else begin
            if (g >= 1) m_rr = (g == NUM_REQ - 1) ? 1 : g + 1;
            for (int i = 1; i < NUM_REQ; i++) begin
                if (!v[i] || g == i) m_wait[i] = 0;
                else if (m_wait[i] < MAX_WAIT) m_wait[i]++;
            end
            if (g >= 0) begin
                if (wr[g]) begin
                    for (int b = 0; b < BW; b++)
                        if (m[g][b]) shadow[a[g]][b*8 +: 8] = d[g][b*8 +: 8];
                end else begin
                    sbq.push_back('{id: g, data: shadow[a[g]], due: cyc + RD_LAT});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        step_check();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_req(int i, logic w, logic [AW-1:0] ad, logic [DW-1:0] dt, logic [BW-1:0] mk);
        v[i] = 1'b1; wr[i] = w; a[i] = ad; d[i] = dt; m[i] = mk;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) shadow[k] = init_word(k);
        m_rr = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_wait[i] = 0; a[i] = '0; d[i] = '0; m[i] = '0;
        end
        v = '0; wr = '0;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        mon_en = 1'b1;

        // Reset / idle
        repeat (3) begin
            tick();
            chk("rst_ready", last_rdy, 0);
            chk("rst_cen", last_cen, 0);
            chk("rst_gid", last_gid, 0);
            chk("rst_rspv", last_rspv, 0);
        end
        HRESET = 1'b0;
        tick();

        // Single read of the preloaded word
        set_req(2, 1'b0, 10'h010, 32'h0, 4'h0);
        tick();
        chk("rd_ready", last_rdy, 4'b0100);
        chk("rd_addr", last_addr, 10'h010);
        v[2] = 1'b0;
        tick();
        tick();
        chk("rd_rspv", last_rspv, 4'b0100);
        chk("rd_data", last_rdata, 32'hDEAD_BEEF);

        // Masked write then read-back
        set_req(1, 1'b1, 10'h3FF, 32'hA5A5_0000, 4'b1100);
        tick();
        wr[1] = 1'b0;
        tick();
        v[1] = 1'b0;
        tick();
        tick();
        chk("wr_rd_rspv", last_rspv, 4'b0010);
        chk("wr_rd_data", last_rdata, 32'hA5A5_1111);

        // Round-robin among native ports from a fresh pointer
        HRESET = 1'b1; tick(); HRESET = 1'b0;
        for (int i = 1; i < NUM_REQ; i++) set_req(i, 1'b1, AW'(10'h100 + i), $urandom, 4'hF);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_gid", last_gid, (k % 3) + 1);
            chk("rr_ovr", last_ovr, 0);
        end
        v = '0;
        tick();

        // Starvation override against a continuously requesting port 0
        set_req(0, 1'b0, 10'h005, 32'h0, 4'h0);
        set_req(3, 1'b0, 10'h006, 32'h0, 4'h0);
        for (int k = 0; k < MAX_WAIT; k++) begin
            tick();
            chk("stv_p0", last_gid, 0);
        end
        tick();
        chk("stv_gid", last_gid, 3);
        chk("stv_ovr", last_ovr, 1);
        tick();
        chk("stv_resume", last_gid, 0);
        chk("stv_resume_ovr", last_ovr, 0);
        v = '0;
        repeat (RD_LAT + 1) tick();

        // Reset while a read is in flight
        set_req(1, 1'b0, 10'h020, 32'h0, 4'h0);
        tick();
        chk("mid_grant", last_rdy, 4'b0010);
        v[1] = 1'b0;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        tick();
        chk("mid_rspv", last_rspv, 0);
        chk("mid_rdata", last_rdata, 0);
        chk("mid_cen", last_cen, 0);
        chk("mid_gid", last_gid, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_g == i) v[i] = 1'b0;
                else if (v[i] && $urandom_range(0, 15) == 0) v[i] = 1'b0;
                if (!v[i] && $urandom_range(0, 99) < ((i == 0) ? 25 : 45))
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                            $urandom, BW'($urandom_range(0, 15)));
            end
            tick();
        end
        v = '0;
        repeat (RD_LAT + 2) tick();
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moc_bank_arbiter.md
Name: moc_bank_arbiter

Overview:
Single-port SRAM bank arbiter for the memory-bank subsystem. It shares one RAM macro between NUM_REQ requesters: requester 0 is the AHB-side port, which is latency-critical, and requesters 1..NUM_REQ-1 are TCM/DMA-style native ports. It issues at most one RAM access per cycle. Arbitration is fixed-priority for port 0 and round-robin among the others, with an anti-starvation override. Read data is returned through a per-requester response pipeline with fixed latency.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RAM_ADDR_W, 10, RAM word-address width
RAM_DATA_W, 32, RAM data width
BYTE_W, RAM_DATA_W/8, write-mask width (1 bit per byte)
RD_LAT, 1, RAM read latency in cycles (1 or 2)
MAX_WAIT, 7, consecutive denied cycles before a starvation override (1..255)

Ports:
HCLK  in  1  clock
HRESET  in  1  reset; one clock; reset is synchronous and active-high
req_valid  in  NUM_REQ  access request per requester
req_ready  out  NUM_REQ  grant; a transfer occurs when valid&ready in the same cycle
req_wr  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*RAM_ADDR_W  word address, packed by requester
req_wdata  in  NUM_REQ*RAM_DATA_W  write data, packed
req_wmask  in  NUM_REQ*BYTE_W  byte enables, 1=write byte
rsp_valid  out  NUM_REQ  read data valid for that requester
rsp_rdata  out  RAM_DATA_W  read data, shared by all requesters
ram_cen  out  1  RAM access enable, active-high
ram_wen  out  1  RAM write enable, active-high
ram_addr  out  RAM_ADDR_W  RAM address
ram_wdata  out  RAM_DATA_W  RAM write data
ram_wmask  out  BYTE_W  RAM byte mask
ram_rdata  in  RAM_DATA_W  RAM read data, valid RD_LAT cycles after a read access
grant_id  out  $clog2(NUM_REQ)  index of current grantee; 0 when idle
starve_ovr  out  1  high in any cycle where the grant came from the starvation override

Behaviour:
- Grant selection is combinational from current req_valid and registered state. At most one bit of req_ready is high; it is high only where req_valid is high. Grant is same-cycle: there is no idle cycle between back-to-back grants.
- Priority, evaluated in order:
  (1) Starvation override: the lowest-index requester i≥1 whose wait_cnt[i] == MAX_WAIT and whose req_valid[i] is high.
  (2) Requester 0, if valid.
  (3) Round-robin among 1..NUM_REQ-1, starting at rr_ptr.
- rr_ptr: reset value 1. After any grant to i≥1 (including an override), rr_ptr ← i+1, wrapping from NUM_REQ-1 to 1. A grant to port 0 leaves rr_ptr unchanged.
- wait_cnt[i], i≥1:
  - Reset value 0.
  - Cleared when granted or when req_valid[i] is low.
  - Incremented when valid and not granted.
  - Saturates at MAX_WAIT.
- RAM drive when granted: ram_cen=1, ram_wen=req_wr[g], and ram_addr/ram_wdata/ram_wmask come from grantee g. On a read grant, ram_wmask=0.
- RAM drive when idle: ram_cen=0, ram_wen=0, and addr/wdata/wmask are 0.
- Response pipeline: an RD_LAT-deep shift register of {valid, id}, loaded on each read grant. Writes load valid=0.
  - At the output stage, rsp_valid[id]=1 and rsp_rdata=ram_rdata.
  - Otherwise rsp_valid=0 and rsp_rdata=0.
  - The pipeline accepts one entry per cycle; there is no backpressure on responses.
- Requesters must hold addr/wr/wdata/wmask stable while valid and not ready. The arbiter does not register request payloads.
- Simultaneous events:
  - A write followed by a read to the same address in the next cycle returns the new data; the RAM is write-first across cycles, and no bypass is needed.
  - A request deasserted before grant is dropped with no side effects.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, ram_cen=0, ram_wen=0, grant_id=0, starve_ovr=0, all pipeline valids 0, rr_ptr=1.
- Reset mid-operation: in-flight read responses are discarded, meaning no rsp_valid is produced after HRESET for reads granted before it. Outputs take their reset values in the cycle after HRESET is sampled high.
- Starvation override cannot starve port 0 indefinitely: overrides among i≥1 rotate by index order, and the wait counters clear on grant.

Test Plan:
- Reset/idle: hold HRESET 3 cycles, all req_valid=0 → ram_cen=0, req_ready=0, rsp_valid=0, grant_id=0 throughout.
- Single read: RD_LAT=1, RAM preloaded at addr 0x010 with 0xDEADBEEF; req 2 reads 0x010 → req_ready[2] same cycle, ram_addr=0x010; next cycle rsp_valid=4'b0100, rsp_rdata=0xDEADBEEF.
- Write then read: req 1 writes 0xA5A5_0000 to 0x3FF with wmask=4'b1100 over old 0x1111_1111, then reads 0x3FF → rsp_rdata=0xA5A5_1111.
- Round-robin: reqs 1, 2, 3 valid continuously, port 0 idle → grants 1,2,3,1,2,3…; grant_id follows; rr_ptr wraps 3→1.
- Starvation: MAX_WAIT=7, port 0 and port 3 valid continuously → port 0 granted 7 cycles, 8th cycle grant_id=3 with starve_ovr=1, then port 0 resumes.
- Reset mid-read: RD_LAT=2, read granted on cycle N, HRESET high on cycle N+1 → no rsp_valid on N+2; all outputs at reset values.
